// File: rtl/tx_mac_if.sv
// TX FIFO AXI-Stream input plus RGMII byte-level output of the transmit MAC.
// slave = MAC side, master = FIFO/PHY side (drives tdata and the byte strobe).
interface tx_mac_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_tx_axis_tdata;
    logic                  s_tx_axis_tvalid;
    logic                  s_tx_axis_tlast;
    logic                  s_tx_axis_tuser;
    logic                  s_tx_axis_trdy;
    logic [DATA_WIDTH-1:0] mac_rgmii_tx_data;
    logic                  mac_rgmii_tx_en;
    logic                  mac_rgmii_tx_er;
    logic                  rgmii_mac_tx_rdy;

    modport slave (
        input  s_tx_axis_tdata, s_tx_axis_tvalid, s_tx_axis_tlast, s_tx_axis_tuser,
        input  rgmii_mac_tx_rdy,
        output s_tx_axis_trdy, mac_rgmii_tx_data, mac_rgmii_tx_en, mac_rgmii_tx_er
    );

    modport master (
        output s_tx_axis_tdata, s_tx_axis_tvalid, s_tx_axis_tlast, s_tx_axis_tuser,
        output rgmii_mac_tx_rdy,
        input  s_tx_axis_trdy, mac_rgmii_tx_data, mac_rgmii_tx_en, mac_rgmii_tx_er
    );
endinterface

// File: rtl/tx_mac.sv
// Ethernet TX MAC: preamble/SFD, payload, zero pad, FCS, IFG onto RGMII; one byte per tx_rdy strobe.
// Accepted byte appears on tx_data at the same strobe edge; trdy only asserts on strobes in PAYLOAD/DRAIN.
module crc32 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_init,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [31:0]           o_crc
);
    logic [31:0] r_crc;
    logic [31:0] w_crc_nxt;

    // Reflected IEEE 802.3 polynomial, LSB of each byte first.
    always_comb begin
        w_crc_nxt = r_crc;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (w_crc_nxt[0] ^ i_data[i]) w_crc_nxt = (w_crc_nxt >> 1) ^ 32'hEDB8_8320;
            else                          w_crc_nxt = w_crc_nxt >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_crc <= 32'hFFFF_FFFF;
        else if (i_init) r_crc <= 32'hFFFF_FFFF;
        else if (i_en)   r_crc <= w_crc_nxt;
    end

    assign o_crc = ~r_crc;
endmodule

module tx_mac #(
    parameter int DATA_WIDTH    = 8,
    parameter int MIN_FRAME_LEN = 60,
    parameter int IFG_BYTES     = 12
) (
    input  logic    clk,
    input  logic    reset,
    tx_mac_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_PAYLOAD, S_PAD, S_FCS, S_DRAIN, S_IFG
    } state_t;

    localparam int                    CNT_W    = $clog2(IFG_BYTES + 8);
    localparam logic [CNT_W-1:0]      PRE_LAST = CNT_W'(6);
    localparam logic [CNT_W-1:0]      IFG_LAST = CNT_W'(IFG_BYTES - 1);
    localparam logic [11:0]           MIN_LEN  = 12'(MIN_FRAME_LEN);
    localparam logic [10:0]           BYTE_MAX = 11'h7FF;
    localparam logic [DATA_WIDTH-1:0] PRE_BYTE = DATA_WIDTH'(8'h55);
    localparam logic [DATA_WIDTH-1:0] SFD_BYTE = DATA_WIDTH'(8'hD5);

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [10:0]           r_byte_cnt, w_byte_cnt_nxt, w_byte_inc;
    logic [11:0]           w_len_nxt;
    logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_nxt, w_crc_data;
    logic                  r_tx_en, w_tx_en_nxt;
    logic                  r_tx_er, w_tx_er_nxt;
    logic                  w_strobe, w_crc_init, w_crc_en;
    logic [31:0]           w_crc;
    logic [7:0]            w_fcs_byte;

    assign w_strobe   = bus.rgmii_mac_tx_rdy;
    assign w_byte_inc = (r_byte_cnt == BYTE_MAX) ? r_byte_cnt : r_byte_cnt + 11'd1;
    assign w_len_nxt  = {1'b0, r_byte_cnt} + 12'd1;

    assign bus.s_tx_axis_trdy    = !reset && w_strobe && (r_state == S_PAYLOAD || r_state == S_DRAIN);
    assign bus.mac_rgmii_tx_data = r_tx_data;
    assign bus.mac_rgmii_tx_en   = r_tx_en;
    assign bus.mac_rgmii_tx_er   = r_tx_er;

    crc32 #(.DATA_WIDTH(DATA_WIDTH)) u_crc (
        .clk    (clk),
        .rst    (reset),
        .i_init (w_crc_init && w_strobe),
        .i_en   (w_crc_en && w_strobe),
        .i_data (w_crc_data),
        .o_crc  (w_crc)
    );

    // FCS goes out least significant byte first.
    always_comb begin
        case (r_cnt[1:0])
            2'd0:    w_fcs_byte = w_crc[7:0];
            2'd1:    w_fcs_byte = w_crc[15:8];
            2'd2:    w_fcs_byte = w_crc[23:16];
            default: w_fcs_byte = w_crc[31:24];
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_tx_data_nxt  = '0;
        w_tx_en_nxt    = 1'b0;
        w_tx_er_nxt    = 1'b0;
        w_crc_init     = 1'b0;
        w_crc_en       = 1'b0;
        w_crc_data     = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.s_tx_axis_tvalid) begin
                    w_tx_data_nxt = PRE_BYTE;
                    w_tx_en_nxt   = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                w_tx_en_nxt = 1'b1;
                if (r_cnt < PRE_LAST) begin
                    w_tx_data_nxt = PRE_BYTE;
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                end else begin
                    w_tx_data_nxt  = SFD_BYTE;
                    w_crc_init     = 1'b1;
                    w_byte_cnt_nxt = '0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                w_tx_en_nxt = 1'b1;
                if (bus.s_tx_axis_tvalid) begin
                    w_tx_data_nxt  = bus.s_tx_axis_tdata;
                    w_crc_en       = 1'b1;
                    w_crc_data     = bus.s_tx_axis_tdata;
                    w_byte_cnt_nxt = w_byte_inc;
                    if (bus.s_tx_axis_tlast) begin
                        w_cnt_nxt = '0;
                        if (bus.s_tx_axis_tuser) begin
                            w_tx_er_nxt = 1'b1;
                            w_state_nxt = S_IFG;
                        end else if (w_len_nxt < MIN_LEN) begin
                            w_state_nxt = S_PAD;
                        end else begin
                            w_state_nxt = S_FCS;
                        end
                    end
                end else begin
                    // Underrun: poison the frame on the wire, then swallow the rest of it.
                    w_tx_er_nxt = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_PAD: begin
                w_tx_en_nxt    = 1'b1;
                w_crc_en       = 1'b1;
                w_byte_cnt_nxt = w_byte_inc;
                if (w_len_nxt >= MIN_LEN) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FCS;
                end
            end
            S_FCS: begin
                w_tx_en_nxt   = 1'b1;
                w_tx_data_nxt = DATA_WIDTH'(w_fcs_byte);
                if (r_cnt[1:0] == 2'd3) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IFG;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (bus.s_tx_axis_tvalid && bus.s_tx_axis_tlast) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IFG;
                end
            end
            S_IFG: begin
                if (r_cnt == IFG_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_byte_cnt <= '0;
            r_tx_data  <= '0;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
        end else if (w_strobe) begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_en    <= w_tx_en_nxt;
            r_tx_er    <= w_tx_er_nxt;
        end
    end
endmodule

// File: tb/tb_tx_mac.sv
// Directed bench for tx_mac: an unpadded instance and a default (60-byte pad) instance share clk/reset.
module tb_tx_mac;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tx_mac_if #(.DATA_WIDTH(8)) if0 ();
    tx_mac_if #(.DATA_WIDTH(8)) if1 ();

    tx_mac #(.DATA_WIDTH(8), .MIN_FRAME_LEN(0), .IFG_BYTES(12)) u_nopad (
        .clk(clk), .reset(reset), .bus(if0));
    tx_mac #(.DATA_WIDTH(8), .MIN_FRAME_LEN(60), .IFG_BYTES(12)) u_pad (
        .clk(clk), .reset(reset), .bus(if1));

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] src_d[$];
    logic       src_v[$], src_l[$], src_u[$];
    int         src_idx;
    logic [7:0] cap_d[$];
    logic       cap_en[$], cap_er[$];
    logic [7:0] exp_d[$];
    logic       exp_en[$], exp_er[$], exp_x[$];
    int         nonstb_chg;

    task automatic clear_all();
        src_d.delete(); src_v.delete(); src_l.delete(); src_u.delete();
        cap_d.delete(); cap_en.delete(); cap_er.delete();
        exp_d.delete(); exp_en.delete(); exp_er.delete(); exp_x.delete();
        src_idx = 0;
        nonstb_chg = 0;
    endtask

    task automatic push_src(input logic [7:0] d, input logic v, input logic l, input logic u);
        src_d.push_back(d); src_v.push_back(v); src_l.push_back(l); src_u.push_back(u);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic en, input logic er, input logic x);
        exp_d.push_back(d); exp_en.push_back(en); exp_er.push_back(er); exp_x.push_back(x);
    endtask

    task automatic push_hdr();
        for (int i = 0; i < 7; i++) push_exp(8'h55, 1'b1, 1'b0, 1'b0);
        push_exp(8'hD5, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_exp(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_check_frame();
        for (int i = 0; i < 9; i++) push_src(8'h31 + 8'(i), 1'b1, (i == 8), 1'b0);
        push_hdr();
        for (int i = 0; i < 9; i++) push_exp(8'h31 + 8'(i), 1'b1, 1'b0, 1'b0);
        push_exp(8'h26, 1'b1, 1'b0, 1'b0);
        push_exp(8'h39, 1'b1, 1'b0, 1'b0);
        push_exp(8'hF4, 1'b1, 1'b0, 1'b0);
        push_exp(8'hCB, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic drive(input logic sel, input logic stb, input logic v, input logic [7:0] d,
                         input logic l, input logic u);
        if0.rgmii_mac_tx_rdy = stb;
        if1.rgmii_mac_tx_rdy = stb;
        if0.s_tx_axis_tvalid = !sel && v;
        if0.s_tx_axis_tdata  = sel ? 8'h00 : d;
        if0.s_tx_axis_tlast  = !sel && l;
        if0.s_tx_axis_tuser  = !sel && u;
        if1.s_tx_axis_tvalid = sel && v;
        if1.s_tx_axis_tdata  = sel ? d : 8'h00;
        if1.s_tx_axis_tlast  = sel && l;
        if1.s_tx_axis_tuser  = sel && u;
    endtask

    task automatic sample(input logic sel, output logic [7:0] d, output logic en, output logic er);
        if (sel) begin
            d = if1.mac_rgmii_tx_data; en = if1.mac_rgmii_tx_en; er = if1.mac_rgmii_tx_er;
        end else begin
            d = if0.mac_rgmii_tx_data; en = if0.mac_rgmii_tx_en; er = if0.mac_rgmii_tx_er;
        end
    endtask

    // Called at a negedge; strobe on cycles where c % period == 0; outputs captured on strobe edges.
    task automatic run(input logic sel, input int period, input int ncyc);
        logic [7:0] pd, cd;
        logic       pen, per, cen, cer, tr;
        sample(sel, pd, pen, per);
        for (int c = 0; c < ncyc; c++) begin
            logic stb;
            stb = ((c % period) == 0);
            if (src_idx < src_d.size())
                drive(sel, stb, src_v[src_idx], src_d[src_idx], src_l[src_idx], src_u[src_idx]);
            else
                drive(sel, stb, 1'b0, 8'h00, 1'b0, 1'b0);
            #1;
            tr = sel ? if1.s_tx_axis_trdy : if0.s_tx_axis_trdy;
            @(posedge clk);
            if (tr === 1'b1 && src_idx < src_d.size()) src_idx++;
            @(negedge clk);
            sample(sel, cd, cen, cer);
            if (stb) begin
                cap_d.push_back(cd); cap_en.push_back(cen); cap_er.push_back(cer);
            end else if ({cd, cen, cer} !== {pd, pen, per}) begin
                nonstb_chg++;
            end
            pd = cd; pen = cen; per = cer;
        end
    endtask

    function automatic int first_en(input int from);
        for (int i = from; i < cap_en.size(); i++) if (cap_en[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_en();
        int n = 0;
        foreach (cap_en[i]) if (cap_en[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r = c;
        for (int b = 0; b < 8; b++) r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        if0.s_tx_axis_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({if1.mac_rgmii_tx_data, if1.mac_rgmii_tx_en, if1.mac_rgmii_tx_er} !== 10'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got d=%02h en=%b er=%b, want 00/0/0",
                     if1.mac_rgmii_tx_data, if1.mac_rgmii_tx_en, if1.mac_rgmii_tx_er);
        end
        n_vec++;
        if ({if0.s_tx_axis_trdy, if1.s_tx_axis_trdy} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_trdy: got %b%b, want 00", if0.s_tx_axis_trdy, if1.s_tx_axis_trdy);
        end
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({if1.mac_rgmii_tx_en, if1.s_tx_axis_trdy} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_after_reset: got en=%b trdy=%b, want 0/0",
                     if1.mac_rgmii_tx_en, if1.s_tx_axis_trdy);
        end
    endtask

    task automatic test_nopad();
        int f;
        clear_all();
        load_check_frame();
        push_idle(12);
        run(1'b0, 1, 50);
        f = first_en(0);
        n_vec++;
        if (f < 0 || f + exp_d.size() > cap_d.size()) begin
            n_err++;
            $display("FAIL nopad_frame: start=%0d captured=%0d, want %0d strobes", f, cap_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_vec++;
                if ({cap_d[f+i], cap_en[f+i], cap_er[f+i]} !== {exp_d[i], exp_en[i], exp_er[i]}) begin
                    n_err++;
                    $display("FAIL nopad_byte[%0d]: got %02h/%b/%b, want %02h/%b/%b", i,
                             cap_d[f+i], cap_en[f+i], cap_er[f+i], exp_d[i], exp_en[i], exp_er[i]);
                end
            end
        end
        n_vec++;
        if (count_en() !== 21) begin
            n_err++;
            $display("FAIL nopad_en_len: got %0d, want 21", count_en());
        end
    endtask

    task automatic test_padded();
        int f;
        logic [7:0] fr [0:13];
        logic [31:0] r;
        clear_all();
        fr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h06};
        for (int i = 0; i < 14; i++) push_src(fr[i], 1'b1, (i == 13), 1'b0);
        push_hdr();
        for (int i = 0; i < 14; i++) push_exp(fr[i], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 46; i++) push_exp(8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)  push_exp(8'h00, 1'b1, 1'b0, 1'b1);
        push_idle(12);
        run(1'b1, 1, 100);
        f = first_en(0);
        n_vec++;
        if (f < 0 || f + exp_d.size() > cap_d.size()) begin
            n_err++;
            $display("FAIL pad_frame: start=%0d captured=%0d, want %0d strobes", f, cap_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_vec++;
                if (exp_x[i] ? ({cap_en[f+i], cap_er[f+i]} !== {exp_en[i], exp_er[i]})
                             : ({cap_d[f+i], cap_en[f+i], cap_er[f+i]} !== {exp_d[i], exp_en[i], exp_er[i]})) begin
                    n_err++;
                    $display("FAIL pad_byte[%0d]: got %02h/%b/%b, want %02h/%b/%b", i,
                             cap_d[f+i], cap_en[f+i], cap_er[f+i], exp_d[i], exp_en[i], exp_er[i]);
                end
            end
            r = 32'hFFFF_FFFF;
            for (int i = 8; i < 72; i++) r = crc_upd(r, cap_d[f+i]);
            n_vec++;
            if (r !== 32'hDEBB_20E3) begin
                n_err++;
                $display("FAIL pad_fcs_residue: got %08h, want debb20e3", r);
            end
        end
        n_vec++;
        if (count_en() !== 72) begin
            n_err++;
            $display("FAIL pad_en_len: got %0d, want 72", count_en());
        end
    endtask

    task automatic test_slow_strobe();
        int f;
        clear_all();
        load_check_frame();
        push_idle(12);
        run(1'b0, 10, 500);
        f = first_en(0);
        n_vec++;
        if (f < 0 || f + exp_d.size() > cap_d.size()) begin
            n_err++;
            $display("FAIL slow_frame: start=%0d captured=%0d, want %0d strobes", f, cap_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_vec++;
                if ({cap_d[f+i], cap_en[f+i], cap_er[f+i]} !== {exp_d[i], exp_en[i], exp_er[i]}) begin
                    n_err++;
                    $display("FAIL slow_byte[%0d]: got %02h/%b/%b, want %02h/%b/%b", i,
                             cap_d[f+i], cap_en[f+i], cap_er[f+i], exp_d[i], exp_en[i], exp_er[i]);
                end
            end
        end
        n_vec++;
        if (nonstb_chg !== 0) begin
            n_err++;
            $display("FAIL slow_hold: got %0d output changes between strobes, want 0", nonstb_chg);
        end
        n_vec++;
        if (count_en() !== 21) begin
            n_err++;
            $display("FAIL slow_en_len: got %0d, want 21", count_en());
        end
    endtask

    task automatic test_underrun();
        int f;
        clear_all();
        for (int i = 0; i < 5; i++) push_src(8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0);
        push_src(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push_src(8'hB0 + 8'(i), 1'b1, (i == 2), 1'b0);
        push_hdr();
        for (int i = 0; i < 5; i++) push_exp(8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0);
        push_exp(8'h00, 1'b1, 1'b1, 1'b0);
        push_idle(15);
        run(1'b1, 1, 60);
        f = first_en(0);
        n_vec++;
        if (f < 0 || f + exp_d.size() > cap_d.size()) begin
            n_err++;
            $display("FAIL underrun_frame: start=%0d captured=%0d, want %0d strobes", f, cap_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_vec++;
                if ({cap_d[f+i], cap_en[f+i], cap_er[f+i]} !== {exp_d[i], exp_en[i], exp_er[i]}) begin
                    n_err++;
                    $display("FAIL underrun_byte[%0d]: got %02h/%b/%b, want %02h/%b/%b", i,
                             cap_d[f+i], cap_en[f+i], cap_er[f+i], exp_d[i], exp_en[i], exp_er[i]);
                end
            end
        end
        n_vec++;
        if (src_idx !== 9) begin
            n_err++;
            $display("FAIL underrun_drained: got %0d source entries consumed, want 9", src_idx);
        end
        n_vec++;
        if (count_en() !== 14) begin
            n_err++;
            $display("FAIL underrun_en_len: got %0d, want 14", count_en());
        end
    endtask

    task automatic test_abort();
        int f;
        clear_all();
        for (int i = 0; i < 20; i++) push_src(8'h60 + 8'(i), 1'b1, (i == 19), (i == 4 || i == 19));
        push_hdr();
        for (int i = 0; i < 20; i++) push_exp(8'h60 + 8'(i), 1'b1, (i == 19), 1'b0);
        push_idle(12);
        run(1'b1, 1, 60);
        f = first_en(0);
        n_vec++;
        if (f < 0 || f + exp_d.size() > cap_d.size()) begin
            n_err++;
            $display("FAIL abort_frame: start=%0d captured=%0d, want %0d strobes", f, cap_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_vec++;
                if ({cap_d[f+i], cap_en[f+i], cap_er[f+i]} !== {exp_d[i], exp_en[i], exp_er[i]}) begin
                    n_err++;
                    $display("FAIL abort_byte[%0d]: got %02h/%b/%b, want %02h/%b/%b", i,
                             cap_d[f+i], cap_en[f+i], cap_er[f+i], exp_d[i], exp_en[i], exp_er[i]);
                end
            end
        end
        n_vec++;
        if (count_en() !== 28) begin
            n_err++;
            $display("FAIL abort_en_len: got %0d, want 28", count_en());
        end
    endtask

    task automatic test_back_to_back();
        int f, f2;
        logic [31:0] r;
        clear_all();
        load_check_frame();
        push_idle(12);
        for (int i = 0; i < 3; i++) push_src(8'h41 + 8'(i), 1'b1, (i == 2), 1'b0);
        push_hdr();
        for (int i = 0; i < 3; i++) push_exp(8'h41 + 8'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push_exp(8'h00, 1'b1, 1'b0, 1'b1);
        push_idle(1);
        run(1'b0, 1, 70);
        f = first_en(0);
        n_vec++;
        if (f < 0 || f + exp_d.size() > cap_d.size()) begin
            n_err++;
            $display("FAIL b2b_frames: start=%0d captured=%0d, want %0d strobes", f, cap_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                n_vec++;
                if (exp_x[i] ? ({cap_en[f+i], cap_er[f+i]} !== {exp_en[i], exp_er[i]})
                             : ({cap_d[f+i], cap_en[f+i], cap_er[f+i]} !== {exp_d[i], exp_en[i], exp_er[i]})) begin
                    n_err++;
                    $display("FAIL b2b_byte[%0d]: got %02h/%b/%b, want %02h/%b/%b", i,
                             cap_d[f+i], cap_en[f+i], cap_er[f+i], exp_d[i], exp_en[i], exp_er[i]);
                end
            end
            f2 = first_en(f + 21);
            n_vec++;
            if (f2 - (f + 21) !== 12) begin
                n_err++;
                $display("FAIL b2b_gap: got %0d idle strobes, want 12", f2 - (f + 21));
            end
            r = 32'hFFFF_FFFF;
            for (int i = 41; i < 48; i++) r = crc_upd(r, cap_d[f+i]);
            n_vec++;
            if (r !== 32'hDEBB_20E3) begin
                n_err++;
                $display("FAIL b2b_fcs_residue: got %08h, want debb20e3", r);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_all();
        for (int i = 0; i < 30; i++) push_src(8'h80 + 8'(i), 1'b1, (i == 29), 1'b0);
        run(1'b1, 1, 12);
        n_vec++;
        if ({if1.mac_rgmii_tx_data, if1.mac_rgmii_tx_en, if1.s_tx_axis_trdy} !== {8'h83, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL mid_before_reset: got d=%02h en=%b trdy=%b, want 83/1/1",
                     if1.mac_rgmii_tx_data, if1.mac_rgmii_tx_en, if1.s_tx_axis_trdy);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({if1.mac_rgmii_tx_data, if1.mac_rgmii_tx_en, if1.mac_rgmii_tx_er, if1.s_tx_axis_trdy} !== 11'h000) begin
            n_err++;
            $display("FAIL mid_reset_async: got d=%02h en=%b er=%b trdy=%b, want 00/0/0/0",
                     if1.mac_rgmii_tx_data, if1.mac_rgmii_tx_en, if1.mac_rgmii_tx_er, if1.s_tx_axis_trdy);
        end
        clear_all();
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run(1'b1, 1, 20);
        n_vec++;
        if (count_en() !== 0) begin
            n_err++;
            $display("FAIL mid_after_reset_idle: got %0d tx_en strobes, want 0", count_en());
        end
    endtask

    initial begin
        test_reset();
        test_nopad();
        test_padded();
        test_slow_strobe();
        test_underrun();
        test_abort();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
